// File: rtl/mux_scan_sel_pkg.sv
// Shared helpers and types for the registered scan/manual channel selector.
package mux_pkg;

    function automatic int sel_width(input int n);
        int r;
        r = $clog2(n);
        if (r < 1) begin
            return 1;
        end else begin
            return r;
        end
    endfunction

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_scan_sel_rr_next_chan.sv
// Round-robin search: first enabled channel strictly above i_ch, wrapping to 0.
module rr_next_chan
    import mux_pkg::*;
#(
    parameter  int NCH = 8,
    localparam int SW  = sel_width(NCH)
) (
    input  logic [SW-1:0]  i_ch,
    input  logic [NCH-1:0] i_en_mask,
    output logic [SW-1:0]  o_next,
    output logic           o_any_en,
    output logic           o_wrapped
);

    logic [NCH-1:0] w_rot;
    logic [SW:0]    w_idx;
    logic [SW:0]    w_off;
    logic [SW:0]    w_sum;
    logic           w_found;

    // Rotate the mask so that bit 0 is the channel just above i_ch.
    always_comb begin
        w_rot = '0;
        w_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            w_idx = {1'b0, i_ch} + (SW+1)'(i + 1);
            if (w_idx >= (SW+1)'(NCH)) begin
                w_idx = w_idx - (SW+1)'(NCH);
            end else begin
                w_idx = w_idx;
            end
            w_rot[i] = i_en_mask[w_idx[SW-1:0]];
        end
    end

    // Priority-encode the rotated mask, then map the offset back to a channel.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = (SW+1)'(i);
            end else begin
                w_found = w_found;
            end
        end
        w_sum = {1'b0, i_ch} + w_off + (SW+1)'(1);
        if (w_sum >= (SW+1)'(NCH)) begin
            w_sum = w_sum - (SW+1)'(NCH);
        end else begin
            w_sum = w_sum;
        end
    end

    assign o_next    = w_sum[SW-1:0];
    assign o_any_en  = w_found;
    assign o_wrapped = w_found && (w_sum[SW-1:0] <= i_ch);

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual load and masked round-robin auto-scan.
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter  int NCH   = 8,
    parameter  int W     = 1,
    parameter  int DWELL = 16,
    localparam int SW    = sel_width(NCH),
    localparam int DWW   = sel_width(DWELL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] din,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic             sel_we,
    input  logic [NCH-1:0]   en_mask,
    output logic [W-1:0]     dout,
    output logic [SW-1:0]    ch,
    output logic             valid,
    output logic             wrap
);

    logic [SW-1:0]  r_ch;
    logic [DWW-1:0] r_dwell;
    logic [W-1:0]   r_dout;
    logic           r_valid;
    logic           r_wrap;
    logic           r_mode_d;

    logic [SW-1:0]  w_rr_next;
    logic           w_any_en;
    logic           w_rr_wrapped;
    logic           w_scan;
    logic           w_sel_ok;
    logic [DWW-1:0] w_dwell_cur;
    logic [SW-1:0]  w_ch_next;
    logic [DWW-1:0] w_dwell_next;
    logic           w_wrap_next;
    logic [W-1:0]   w_dout_next;

    rr_next_chan #(
        .NCH (NCH)
    ) u_rr (
        .i_ch      (r_ch),
        .i_en_mask (en_mask),
        .o_next    (w_rr_next),
        .o_any_en  (w_any_en),
        .o_wrapped (w_rr_wrapped)
    );

    assign w_scan      = (mode_e'(mode) == MODE_SCAN);
    assign w_sel_ok    = ({1'b0, sel} < (SW+1)'(NCH));
    // Entering scan restarts the dwell so the current channel gets a full slot.
    assign w_dwell_cur = (w_scan && !r_mode_d) ? '0 : r_dwell;

    // Channel/dwell/wrap next-state: valid load, then scan advance, then hold.
    always_comb begin
        w_ch_next    = r_ch;
        w_dwell_next = '0;
        w_wrap_next  = 1'b0;
        if (sel_we && w_sel_ok) begin
            w_ch_next = sel;
        end else if (w_scan && w_any_en) begin
            if (w_dwell_cur == DWW'(DWELL - 1)) begin
                w_ch_next   = w_rr_next;
                w_wrap_next = w_rr_wrapped;
            end else begin
                w_dwell_next = w_dwell_cur + DWW'(1);
            end
        end else begin
            w_dwell_next = '0;
        end
    end

    // Data-select loop over all channels.
    always_comb begin
        w_dout_next = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_ch_next == SW'(k)) begin
                w_dout_next = din[k*W +: W];
            end else begin
                w_dout_next = w_dout_next;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_dwell  <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_mode_d <= 1'b0;
        end else begin
            r_ch     <= w_ch_next;
            r_dwell  <= w_dwell_next;
            r_dout   <= w_dout_next;
            r_valid  <= en_mask[w_ch_next];
            r_wrap   <= w_wrap_next;
            r_mode_d <= mode;
        end
    end

    assign dout  = r_dout;
    assign ch    = r_ch;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed-sequence bench with random channel data, checked against a cycle model.
module tb_mux_scan_sel;

    localparam int NCH   = 8;
    localparam int W     = 4;
    localparam int DWELL = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        mode;
    logic [2:0]  sel;
    logic        sel_we;
    logic [7:0]  en_mask;
    logic [3:0]  dout;
    logic [2:0]  ch;
    logic        valid;
    logic        wrap;

    int n_cmp = 0;
    int n_err = 0;
    int wraps = 0;

    int         m_ch;
    int         m_cnt;
    logic       m_mode_d;
    logic [3:0] m_dout;
    logic       m_valid;
    logic       m_wrap;

    mux_scan_sel #(
        .NCH   (NCH),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .mode    (mode),
        .sel     (sel),
        .sel_we  (sel_we),
        .en_mask (en_mask),
        .dout    (dout),
        .ch      (ch),
        .valid   (valid),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ch     = 0;
        m_cnt    = 0;
        m_mode_d = 1'b0;
        m_dout   = 4'h0;
        m_valid  = 1'b0;
        m_wrap   = 1'b0;
    endtask

    function automatic int next_enabled(input int from, input logic [7:0] mask);
        logic [7:0] t;
        for (int d = 1; d <= NCH; d++) begin
            t = mask >> ((from + d) % NCH);
            if (t[0]) return (from + d) % NCH;
        end
        return from;
    endfunction

    // One clock: predict from the rules, advance, then compare every output.
    task automatic tick();
        int         nch;
        int         ncnt;
        int         cnt;
        logic       nwrap;
        logic [7:0] t;
        logic [31:0] dsh;
        din = $urandom;
        if (!rst_n) begin
            @(posedge clk);
            #1;
            model_reset();
        end else begin
            cnt   = (mode && !m_mode_d) ? 0 : m_cnt;
            nch   = m_ch;
            ncnt  = 0;
            nwrap = 1'b0;
            if (sel_we && int'(sel) < NCH) begin
                nch = int'(sel);
            end else if (mode && en_mask != 8'h00) begin
                if (cnt == DWELL - 1) begin
                    nch   = next_enabled(m_ch, en_mask);
                    nwrap = (nch <= m_ch);
                end else begin
                    ncnt = cnt + 1;
                end
            end
            dsh = din >> (nch * W);
            t   = en_mask >> nch;
            @(posedge clk);
            #1;
            m_ch     = nch;
            m_cnt    = ncnt;
            m_mode_d = mode;
            m_dout   = dsh[3:0];
            m_valid  = t[0];
            m_wrap   = nwrap;
        end
        check("ch",    32'(ch),    32'(m_ch));
        check("dout",  32'(dout),  32'(m_dout));
        check("valid", 32'(valid), 32'(m_valid));
        check("wrap",  32'(wrap),  32'(m_wrap));
        if (wrap) wraps++;
    endtask

    initial begin
        rst_n   = 1'b0;
        mode    = 1'b0;
        sel     = 3'd0;
        sel_we  = 1'b0;
        en_mask = 8'hA5;
        din     = 32'h0;
        model_reset();

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("release_dout", 32'(dout), 32'(din[3:0]));

        sel = 3'd5; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        check("manual_ch", 32'(ch), 32'd5);
        repeat (2) tick();

        sel = 3'd0; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        mode  = 1'b1;
        wraps = 0;
        repeat (12) tick();
        check("scan_wraps", 32'(wraps), 32'd1);
        check("scan_end_ch", 32'(ch), 32'd0);

        en_mask = 8'h00;
        wraps   = 0;
        repeat (8) tick();
        check("nomask_wraps", 32'(wraps), 32'd0);
        check("nomask_ch", 32'(ch), 32'd0);

        en_mask = 8'h08;
        sel = 3'd3; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        wraps  = 0;
        repeat (9) tick();
        check("single_wraps", 32'(wraps), 32'd3);
        check("single_ch", 32'(ch), 32'd3);

        en_mask = 8'hA5;
        sel = 3'd7; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        for (int g = 0; g < 10 && m_cnt != DWELL - 1; g++) tick();
        check("align_expiry", 32'(m_cnt), 32'(DWELL - 1));
        sel = 3'd6; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        check("collide_ch", 32'(ch), 32'd6);
        check("collide_wrap", 32'(wrap), 32'd0);
        repeat (2) tick();
        check("collide_hold", 32'(ch), 32'd6);
        tick();
        check("collide_adv", 32'(ch), 32'd7);

        tick();
        mode = 1'b0;
        tick();
        mode = 1'b1;
        repeat (2) tick();
        check("reentry_hold", 32'(ch), 32'd7);
        tick();
        check("reentry_adv", 32'(ch), 32'd0);

        sel = 3'd5; sel_we = 1'b1;
        tick();
        sel_we = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ch",    32'(ch),    32'd0);
        check("async_dout",  32'(dout),  32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check("async_wrap",  32'(wrap),  32'd0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        check("resume_ch", 32'(ch), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
